// File: rtl/rob_ctrl_if.sv
// Reorder-buffer controller bus.
// Groups the allocation, fast/slow completion and commit signals of rob_ctrl.
//   master : fetch/execute side; drives alloc_req/alloc_pc and fast_*/slow_*,
//            observes alloc_ok/alloc_index, commit_*, full, empty.
//   slave  : rob_ctrl itself.
interface rob_ctrl_if #(
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned DATA_W = 32
);
  logic              alloc_req;
  logic [DATA_W-1:0] alloc_pc;
  logic              alloc_ok;
  logic [IDX_W-1:0]  alloc_index;

  logic              fast_valid;
  logic [IDX_W-1:0]  fast_index;
  logic [4:0]        fast_rd;
  logic              fast_write;
  logic [DATA_W-1:0] fast_val;

  logic              slow_valid;
  logic [IDX_W-1:0]  slow_index;
  logic [4:0]        slow_rd;
  logic              slow_write;
  logic [DATA_W-1:0] slow_val;

  logic              commit_valid;
  logic [IDX_W-1:0]  commit_index;
  logic [4:0]        commit_rd;
  logic              commit_we;
  logic [DATA_W-1:0] commit_val;
  logic [DATA_W-1:0] commit_pc;

  logic              full;
  logic              empty;

  modport master (
    output alloc_req, alloc_pc,
    output fast_valid, fast_index, fast_rd, fast_write, fast_val,
    output slow_valid, slow_index, slow_rd, slow_write, slow_val,
    input  alloc_ok, alloc_index,
    input  commit_valid, commit_index, commit_rd, commit_we, commit_val, commit_pc,
    input  full, empty
  );

  modport slave (
    input  alloc_req, alloc_pc,
    input  fast_valid, fast_index, fast_rd, fast_write, fast_val,
    input  slow_valid, slow_index, slow_rd, slow_write, slow_val,
    output alloc_ok, alloc_index,
    output commit_valid, commit_index, commit_rd, commit_we, commit_val, commit_pc,
    output full, empty
  );
endinterface

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller for the MIPS pipeline.
// Hands out rob_index tags in program order, accepts out-of-order completions
// from the fast (C_WB) and slow (SLREG) paths, and retires entries strictly in
// order, one per cycle, through registered commit_* outputs.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears all state including stored data
//   flush  synchronous squash of all entries; stored data is left as is
//   bus    rob_ctrl_if.slave: alloc_*, fast_*, slow_*, commit_*, full, empty
// Build option:
//   ROB_BYPASS_EN  a completion hitting the busy, not-done head entry retires
//                  on the edge it is sampled (1-cycle latency), fast first.
module rob_ctrl #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  rob_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [IDX_W-1:0]              head;
  logic [IDX_W-1:0]              tail;
  logic [CNT_W-1:0]              count;
  logic [DEPTH-1:0]              busy;
  logic [DEPTH-1:0]              done;
  logic [DEPTH-1:0]              wr_mem;
  logic [DEPTH-1:0][4:0]         rd_mem;
  logic [DEPTH-1:0][DATA_W-1:0]  pc_mem;
  logic [DEPTH-1:0][DATA_W-1:0]  val_mem;

  logic                          cm_valid;
  logic [IDX_W-1:0]              cm_index;
  logic [4:0]                    cm_rd;
  logic                          cm_we;
  logic [DATA_W-1:0]             cm_val;
  logic [DATA_W-1:0]             cm_pc;

  logic                          full_int;
  logic                          alloc_go;
  logic                          fast_hit;
  logic                          slow_hit;
  logic                          commit_go;
  logic [4:0]                    c_rd;
  logic                          c_we;
  logic [DATA_W-1:0]             c_val;

  // full/empty come from the registered count only; a commit in the same
  // cycle never frees a slot for allocation.
  assign full_int        = (count == CNT_W'(DEPTH));
  assign bus.full        = full_int;
  assign bus.empty       = (count == '0);
  assign bus.alloc_ok    = alloc_go;
  assign bus.alloc_index = tail;

  assign bus.commit_valid = cm_valid;
  assign bus.commit_index = cm_index;
  assign bus.commit_rd    = cm_rd;
  assign bus.commit_we    = cm_we;
  assign bus.commit_val   = cm_val;
  assign bus.commit_pc    = cm_pc;

  always_comb begin
    alloc_go = bus.alloc_req && !full_int;
    fast_hit = bus.fast_valid && busy[bus.fast_index];
    // Slow is dropped when fast lands on the same tag.
    slow_hit = bus.slow_valid && busy[bus.slow_index] &&
               !(fast_hit && (bus.fast_index == bus.slow_index));

    commit_go = busy[head] && done[head];
    c_rd      = rd_mem[head];
    c_we      = wr_mem[head];
    c_val     = val_mem[head];
`ifdef ROB_BYPASS_EN
    if (busy[head] && !done[head]) begin
      if (fast_hit && (bus.fast_index == head)) begin
        commit_go = 1'b1;
        c_rd      = bus.fast_rd;
        c_we      = bus.fast_write;
        c_val     = bus.fast_val;
      end else if (slow_hit && (bus.slow_index == head)) begin
        commit_go = 1'b1;
        c_rd      = bus.slow_rd;
        c_we      = bus.slow_write;
        c_val     = bus.slow_val;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      busy     <= '0;
      done     <= '0;
      wr_mem   <= '0;
      rd_mem   <= '0;
      pc_mem   <= '0;
      val_mem  <= '0;
      cm_valid <= 1'b0;
      cm_index <= '0;
      cm_rd    <= '0;
      cm_we    <= 1'b0;
      cm_val   <= '0;
      cm_pc    <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      busy     <= '0;
      done     <= '0;
      cm_valid <= 1'b0;
      cm_index <= '0;
      cm_rd    <= '0;
      cm_we    <= 1'b0;
      cm_val   <= '0;
      cm_pc    <= '0;
    end else begin
      // tail can only equal a busy head when full, so allocation and commit
      // never touch the same entry in one cycle.
      if (alloc_go) begin
        busy[tail]   <= 1'b1;
        done[tail]   <= 1'b0;
        pc_mem[tail] <= bus.alloc_pc;
        tail         <= tail + IDX_W'(1);
      end

      if (fast_hit) begin
        done[bus.fast_index]    <= 1'b1;
        rd_mem[bus.fast_index]  <= bus.fast_rd;
        wr_mem[bus.fast_index]  <= bus.fast_write;
        val_mem[bus.fast_index] <= bus.fast_val;
      end

      if (slow_hit) begin
        done[bus.slow_index]    <= 1'b1;
        rd_mem[bus.slow_index]  <= bus.slow_rd;
        wr_mem[bus.slow_index]  <= bus.slow_write;
        val_mem[bus.slow_index] <= bus.slow_val;
      end

      if (commit_go) begin
        busy[head] <= 1'b0;
        head       <= head + IDX_W'(1);
        cm_valid   <= 1'b1;
        cm_index   <= head;
        cm_rd      <= c_rd;
        cm_we      <= c_we;
        cm_val     <= c_val;
        cm_pc      <= pc_mem[head];
      end else begin
        cm_valid <= 1'b0;
        cm_we    <= 1'b0;
      end

      case ({alloc_go, commit_go})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
